// File: rtl/writeback_buffer.sv
// Purpose : circular FIFO of evicted dirty cache lines, drained one at a time to a store-data writer;
//           later evictions of a buffered line merge in place, load misses can snoop buffered lines.
// Latency : a pushed line is visible to lookup and count the cycle after acceptance; drain starts
//           at the earliest one IDLE cycle later. Backpressure: push_ready = (count < DEPTH), from
//           registered state only, so a pop in the same cycle does not open a slot for a full buffer.
// Ports   : clk, reset (sync, active low); push_valid/push_addr/push_data/push_ready (eviction input);
//           lookup_addr/lookup_hit/lookup_data (load-miss snoop); wd_enable/wd_addr/wd_data/wd_ready
//           (writer handshake); empty, count (occupancy).
module writeback_buffer #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int DEPTH          = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push_valid,
   input  logic [63:0]                   push_addr,
   input  logic [BUS_DATA_WIDTH*8-1:0]   push_data,
   output logic                          push_ready,
   input  logic [63:0]                   lookup_addr,
   output logic                          lookup_hit,
   output logic [BUS_DATA_WIDTH*8-1:0]   lookup_data,
   output logic                          wd_enable,
   output logic [63:0]                   wd_addr,
   output logic [BUS_DATA_WIDTH*8-1:0]   wd_data,
   input  logic                          wd_ready,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int LINE_W = BUS_DATA_WIDTH * 8;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int TAG_W  = 58;

   typedef enum logic [1:0] {IDLE, ISSUE, WAITLOW, WAITHI} state_t;

   state_t             state;
   logic [TAG_W-1:0]   tag_q  [DEPTH];
   logic [LINE_W-1:0]  data_q [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;

   logic               in_flight;
   logic               push_fire;
   logic               merge_hit;
   logic [PTR_W-1:0]   merge_idx;
   logic [PTR_W-1:0]   lookup_idx;
   logic [PTR_W-1:0]   idx;
   logic               append;
   logic               pop;
   logic               unused_addr_bits;

   // Line offset bits never take part in matching.
   assign unused_addr_bits = ^{push_addr[5:0], lookup_addr[5:0]};

   assign in_flight  = (state != IDLE);
   assign push_ready = (count < CNT_W'(DEPTH));
   assign empty      = (count == '0);
   assign push_fire  = push_valid && push_ready;

   // Walk valid entries oldest to youngest so the last match recorded is the youngest.
   // The head is skipped as a merge target while it is being written out, so the writer
   // never sees its data change underneath it.
   always_comb begin
      merge_hit  = 1'b0;
      merge_idx  = '0;
      lookup_hit = 1'b0;
      lookup_idx = '0;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (CNT_W'(i) < count) begin
            if ((tag_q[idx] == push_addr[63:6]) && !((i == 0) && in_flight)) begin
               merge_hit = 1'b1;
               merge_idx = idx;
            end
            if (tag_q[idx] == lookup_addr[63:6]) begin
               lookup_hit = 1'b1;
               lookup_idx = idx;
            end
         end
      end
   end

   assign lookup_data = data_q[lookup_idx];
   assign append      = push_fire && !merge_hit;
   assign pop         = (state == WAITHI) && wd_ready;

   // Line storage needs no reset: validity is implied by head/count.
   always_ff @(posedge clk) begin
      if (reset && push_fire) begin
         if (merge_hit) begin
            data_q[merge_idx] <= push_data;
         end else begin
            tag_q[tail]  <= push_addr[63:6];
            data_q[tail] <= push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         state     <= IDLE;
         wd_enable <= 1'b0;
         wd_addr   <= '0;
         wd_data   <= '0;
      end else begin
         if (append) tail <= tail + 1'b1;
         if (pop)    head <= head + 1'b1;
         count     <= count + CNT_W'(append) - CNT_W'(pop);
         wd_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  state     <= ISSUE;
                  wd_enable <= 1'b1;
                  wd_addr   <= {tag_q[head], 6'b0};
                  // A merge into the head on this same edge must reach the writer.
                  wd_data   <= (push_fire && merge_hit && (merge_idx == head)) ? push_data
                                                                              : data_q[head];
               end
            end
            ISSUE:   state <= WAITLOW;
            // A ready still high from the previous transfer is not a completion.
            WAITLOW: if (!wd_ready) state <= WAITHI;
            WAITHI:  if (wd_ready)  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus word width; one line = BUS_DATA_WIDTH*8 = 512 bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of line entries (power of two).
REQ-003 SHALL have a single clock and a synchronous, active-low reset; all state updates on rising clk edge.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-low reset (0 = reset).
REQ-006 push_valid  in  1  evicted dirty line offered by D-cache.
REQ-007 push_addr  in  64  line address; only bits [63:6] significant.
REQ-008 push_data  in  512  line data, word 0 in [63:0].
REQ-009 push_ready  out  1  buffer accepts push this cycle.
REQ-010 lookup_addr  in  64  load-miss address to check against buffered lines.
REQ-011 lookup_hit  out  1  a buffered line matches lookup_addr[63:6].
REQ-012 lookup_data  out  512  data of matching line (don't-care when lookup_hit=0).
REQ-013 wd_enable  out  1  start pulse to store-data writer.
REQ-014 wd_addr  out  64  line address to writer, {addr[63:6],6'b0}.
REQ-015 wd_data  out  512  line data to writer.
REQ-016 wd_ready  in  1  writer done/idle indication.
REQ-017 empty  out  1  no valid entries.
REQ-018 count  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-019 SHALL store entries in a circular FIFO (head/tail pointers wrap modulo DEPTH), oldest drained first.
REQ-020 push_ready SHALL equal (count < DEPTH), from registered state only.
REQ-021 Push accepted iff push_valid && push_ready; ignored otherwise, no state change.
REQ-022 Accepted push whose addr[63:6] matches a valid entry other than the in-flight head SHALL overwrite that entry's data in place (merge); count unchanged.
REQ-023 Accepted push with no mergeable match SHALL append at tail; count+1 unless a pop occurs the same cycle.
REQ-024 Drain FSM states IDLE, ISSUE, WAITLOW, WAITHI.
REQ-025 IDLE: !empty -> ISSUE; else stay.
REQ-026 ISSUE: wd_enable=1 for exactly this cycle -> WAITLOW.
REQ-027 WAITLOW: wd_ready==0 -> WAITHI; else stay (stale ready from previous transfer ignored).
REQ-028 WAITHI: wd_ready==1 -> pop head (head+1, count-1) -> IDLE; else stay.
REQ-029 Head is in flight in ISSUE, WAITLOW, WAITHI; wd_addr/wd_data SHALL be driven from head and held stable in those states; head entry SHALL NOT be merged into.
REQ-030 wd_enable SHALL be 0 in all states except ISSUE.
REQ-031 Simultaneous append and pop: both take effect, count unchanged; full buffer with pop same cycle still rejects push (REQ-020).
REQ-032 lookup_hit/lookup_data SHALL be combinational from registered entries; among matches the youngest (non-head over head) wins; same-cycle push not visible until next cycle.
REQ-033 Minimum one IDLE cycle between successive drains.

Reset
REQ-034 While reset==0 at clk edge: all entries invalid, head=tail=0, count=0, FSM=IDLE.
REQ-035 Reset outputs: push_ready=1, empty=1, count=0, wd_enable=0, lookup_hit=0; wd_addr/wd_data=0.
REQ-036 Reset mid-drain SHALL discard all entries including in-flight head, no further wd_enable.

Verification
REQ-037 Single push addr 0x1040, data words 0..7 = 1..8, writer model drops ready 1 cycle after enable and raises 10 cycles later -> one wd_enable pulse, wd_addr=0x1040, wd_data stable, empty=1 one cycle after ready rises.
REQ-038 Push 4 distinct lines with writer stalled (ready held 0) -> count=4, push_ready=0, 5th push ignored; release writer -> drained in push order, count 4..0.
REQ-039 Push 0x2000 data A, then 0x2000 data B while another line is in flight -> count=1 for that address, drained data=B; push 0x2000 while 0x2000 is head in flight -> new entry appended, count+1.
REQ-040 Lookup 0x2010 with 0x2000 buffered -> lookup_hit=1, lookup_data=buffered data; lookup 0x3000 -> lookup_hit=0.
REQ-041 Writer ready stuck high across ISSUE -> FSM stays WAITLOW, no pop until ready seen 0 then 1.
REQ-042 Assert reset (0) during WAITHI with count=3 -> next cycle count=0, empty=1, wd_enable=0, no pop on later wd_ready.
